// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipeline: data-memory loads/stores over a req/ack handshake,
// ALU pass-through, upstream stall while a transaction is outstanding, registered write-back.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [15:0] mem_addr_in,
  input  logic [2:0]  rdest_addr_in,
  input  logic [15:0] rdest_data_in,
  input  logic        store_in,
  input  logic        load_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [2:0]  wb_rdest_addr,
  output logic [15:0] wb_rdest_data,
  output logic [15:0] mem_op_count
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [REG_W-1:0]  r_rd_idx;
  logic              w_is_store;
  logic              w_is_load;
  logic              w_is_alu;
  logic              w_is_mem;

  // Store wins when both load and store are flagged
  assign w_is_store = valid_in & store_in;
  assign w_is_load  = valid_in & load_in & ~store_in;
  assign w_is_alu   = valid_in & ~load_in & ~store_in;
  assign w_is_mem   = w_is_store | w_is_load;

  assign mem_stall  = (r_state == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_is_mem) w_next_state = BUSY;
      BUSY:    if (dmem_ack) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request, write-back and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= ADDR_W'(0);
      dmem_wdata    <= DATA_W'(0);
      r_rd_idx      <= REG_W'(0);
      wb_valid      <= 1'b0;
      wb_rdest_addr <= REG_W'(0);
      wb_rdest_data <= DATA_W'(0);
      mem_op_count  <= CNT_W'(0);
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_is_alu) begin
            wb_rdest_addr <= rdest_addr_in;
            wb_rdest_data <= rdest_data_in;
            wb_valid      <= 1'b1;
          end else if (w_is_mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= w_is_store;
            dmem_addr  <= mem_addr_in;
            dmem_wdata <= rdest_data_in;
            r_rd_idx   <= rdest_addr_in;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            mem_op_count <= mem_op_count + CNT_W'(1);
            if (!dmem_we) begin
              wb_rdest_addr <= r_rd_idx;
              wb_rdest_data <= dmem_rdata;
              wb_valid      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed stimulus pushes expected write-backs,
// a negedge monitor pops and compares whenever wb_valid is presented.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [15:0] mem_addr_in;
  logic [2:0]  rdest_addr_in;
  logic [15:0] rdest_data_in;
  logic        store_in;
  logic        load_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        mem_stall;
  logic        wb_valid;
  logic [2:0]  wb_rdest_addr;
  logic [15:0] wb_rdest_data;
  logic [15:0] mem_op_count;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  mem_access_stage dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .mem_addr_in   (mem_addr_in),
    .rdest_addr_in (rdest_addr_in),
    .rdest_data_in (rdest_data_in),
    .store_in      (store_in),
    .load_in       (load_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .mem_stall     (mem_stall),
    .wb_valid      (wb_valid),
    .wb_rdest_addr (wb_rdest_addr),
    .wb_rdest_data (wb_rdest_data),
    .mem_op_count  (mem_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write-back pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected no write-back at %0t",
                 wb_rdest_addr, wb_rdest_data, $time);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_rdest_addr", 16'(wb_rdest_addr), 16'(e.addr));
        check("wb_rdest_data", wb_rdest_data, e.data);
      end
    end
  end

  task automatic drive_idle();
    valid_in      = 1'b0;
    load_in       = 1'b0;
    store_in      = 1'b0;
    mem_addr_in   = 16'h0000;
    rdest_addr_in = 3'd0;
    rdest_data_in = 16'h0000;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [15:0] addr,
                       input logic [2:0] rd, input logic [15:0] data);
    valid_in      = 1'b1;
    load_in       = ld;
    store_in      = st;
    mem_addr_in   = addr;
    rdest_addr_in = rd;
    rdest_data_in = data;
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 16'h0000;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_dmem_req", 16'(dmem_req), 16'd0);
    check("rst_mem_stall", 16'(mem_stall), 16'd0);
    check("rst_wb_valid", 16'(wb_valid), 16'd0);
    check("rst_count", mem_op_count, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // ALU pass-through
    issue(1'b0, 1'b0, 16'h0000, 3'd5, 16'h1234);
    exp_q.push_back('{addr: 3'd5, data: 16'h1234});
    @(posedge clk); #1;
    drive_idle();
    check("alu_dmem_req", 16'(dmem_req), 16'd0);
    check("alu_stall", 16'(mem_stall), 16'd0);

    // Load with ack after three BUSY cycles
    @(negedge clk);
    issue(1'b1, 1'b0, 16'h00A0, 3'd2, 16'h0000);
    @(posedge clk); #1;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      check("ld_req", 16'(dmem_req), 16'd1);
      check("ld_we", 16'(dmem_we), 16'd0);
      check("ld_addr", dmem_addr, 16'h00A0);
      check("ld_stall", 16'(mem_stall), 16'd1);
      if (i == 2) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hBEEF;
        exp_q.push_back('{addr: 3'd2, data: 16'hBEEF});
      end
      @(posedge clk); #1;
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 16'h0000;
    check("ld_done_req", 16'(dmem_req), 16'd0);
    check("ld_done_stall", 16'(mem_stall), 16'd0);
    check("ld_count", mem_op_count, 16'd1);

    // Store, then ALU held upstream during BUSY, ack on first BUSY cycle
    @(negedge clk);
    issue(1'b0, 1'b1, 16'h0010, 3'd6, 16'h5555);
    @(posedge clk); #1;
    check("st_req", 16'(dmem_req), 16'd1);
    check("st_we", 16'(dmem_we), 16'd1);
    check("st_addr", dmem_addr, 16'h0010);
    check("st_wdata", dmem_wdata, 16'h5555);
    issue(1'b0, 1'b0, 16'h0000, 3'd7, 16'h0BAD);
    exp_q.push_back('{addr: 3'd7, data: 16'h0BAD});
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("st_done_req", 16'(dmem_req), 16'd0);
    check("st_done_stall", 16'(mem_stall), 16'd0);
    check("st_count", mem_op_count, 16'd2);
    @(posedge clk); #1;
    drive_idle();
    check("held_alu_no_req", 16'(dmem_req), 16'd0);
    repeat (2) @(posedge clk);

    // Reset during BUSY abandons the load
    @(negedge clk);
    issue(1'b1, 1'b0, 16'h0100, 3'd1, 16'h0000);
    @(posedge clk); #1;
    drive_idle();
    check("rb_req_before", 16'(dmem_req), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rb_req", 16'(dmem_req), 16'd0);
    check("rb_stall", 16'(mem_stall), 16'd0);
    check("rb_count", mem_op_count, 16'd0);
    check("rb_wb_data", wb_rdest_data, 16'h0000);
    check("rb_wb_addr", 16'(wb_rdest_addr), 16'd0);
    check("rb_addr", dmem_addr, 16'h0000);
    @(negedge clk);
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    check("rb_late_ack_count", mem_op_count, 16'd0);
    check("rb_late_ack_req", 16'(dmem_req), 16'd0);

    // load_in and store_in both set behaves as a store
    @(negedge clk);
    issue(1'b1, 1'b1, 16'h0020, 3'd4, 16'h7777);
    @(posedge clk); #1;
    drive_idle();
    check("pri_we", 16'(dmem_we), 16'd1);
    check("pri_wdata", dmem_wdata, 16'h7777);
    dmem_ack   = 1'b1;
    dmem_rdata = 16'h9999;
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    check("pri_count", mem_op_count, 16'd1);

    // Counter wrap from 0xFFFF
    @(negedge clk);
    force dut.mem_op_count = 16'hFFFF;
    #1;
    release dut.mem_op_count;
    #1;
    check("wrap_preload", mem_op_count, 16'hFFFF);
    @(negedge clk);
    issue(1'b1, 1'b0, 16'h0040, 3'd0, 16'h0000);
    @(posedge clk); #1;
    drive_idle();
    dmem_ack   = 1'b1;
    dmem_rdata = 16'hA5A5;
    exp_q.push_back('{addr: 3'd0, data: 16'hA5A5});
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    check("wrap_count", mem_op_count, 16'h0000);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the 16-bit pipeline. It sits directly downstream of the EX-to-MEM pipeline register and performs data-memory loads and stores through a req/ack handshake. It passes ALU results through to write-back and stalls the upstream register while a memory transaction is outstanding. It also produces registered write-back outputs for the MEM-to-WB register.

## Interface
- No parameters. Address and data are 16 bits, register index is 3 bits.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `valid_in` in 1: an instruction is present on the `*_in` inputs this cycle.
- `mem_addr_in` in 16: data-memory address (load/store).
- `rdest_addr_in` in 3: destination register index.
- `rdest_data_in` in 16: ALU result (ALU op) or store data (store).
- `store_in` in 1: instruction is a store.
- `load_in` in 1: instruction is a load.
- `dmem_req` out 1: memory request, held high until ack.
- `dmem_we` out 1: 1 = write, 0 = read; valid while `dmem_req`.
- `dmem_addr` out 16: memory address; valid while `dmem_req`.
- `dmem_wdata` out 16: store data; valid while `dmem_req`.
- `dmem_ack` in 1: memory completes the request this cycle.
- `dmem_rdata` in 16: read data; valid when `dmem_ack` is high on a read.
- `mem_stall` out 1: high means hold the EX-to-MEM register (drives its write enable low).
- `wb_valid` out 1: one-cycle pulse when a register write-back is produced.
- `wb_rdest_addr` out 3: write-back register index.
- `wb_rdest_data` out 16: write-back data.
- `mem_op_count` out 16: count of completed loads and stores; wraps.

## Operation
- **Instruction classes**
  - Store: `valid_in & store_in`. Store takes priority if `load_in` is also set.
  - Load: `valid_in & load_in & !store_in`.
  - ALU: `valid_in & !load_in & !store_in`.
- **FSM, two states: IDLE and BUSY.** `mem_stall = (state == BUSY)`, decoded combinationally from the state register.
- **IDLE**
  - ALU op: register `wb_rdest_addr <= rdest_addr_in`, `wb_rdest_data <= rdest_data_in`, `wb_valid <= 1`. Stay in IDLE.
  - Load or store: latch the address, data, we (= store) and rdest index into request registers. Set `dmem_req <= 1` and go to BUSY. `wb_valid <= 0`.
  - No valid instruction: `wb_valid <= 0`.
  - `dmem_ack` is ignored in IDLE.
- **BUSY**
  - `valid_in` is ignored. Upstream holds its instruction because `mem_stall = 1`.
  - `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` stay constant.
  - On `dmem_ack = 1`:
    - `dmem_req <= 0`.
    - Increment `mem_op_count` (modulo 2^16; 0xFFFF wraps to 0x0000).
    - Load: `wb_rdest_data <= dmem_rdata`, `wb_rdest_addr <=` latched index, `wb_valid <= 1`.
    - Store: `wb_valid <= 0`.
    - Return to IDLE.
  - Without ack: stay in BUSY, `wb_valid <= 0`.
- **Held-instruction rule.** The instruction held upstream during BUSY is accepted in the IDLE cycle that follows the ack. It is consumed exactly once and never duplicated.
- **Write-back register index.** No special treatment of index 0; it is passed through.

## Timing
- **Reset values (asynchronous, take effect immediately)**
  - State: IDLE.
  - `dmem_req`, `dmem_we`, `wb_valid`: 0.
  - `dmem_addr`, `dmem_wdata`, `wb_rdest_data`: 0x0000.
  - `wb_rdest_addr`: 0. `mem_op_count`: 0. `mem_stall`: 0.
- **Reset mid-transaction:** `dmem_req` drops at once, the pending operation is abandoned, and no count increment or write-back occurs.
- **ALU latency:** accepted at edge N; `wb_valid` is high during the cycle after N.
- **Load/store request:** accepted at edge N; `dmem_req` is high from edge N.
- **Completion:** ack sampled at edge M (M ≥ N+1); `dmem_req` falls and `wb_valid` (loads only) rises at edge M.
- **Minimum occupancy:** a memory op occupies at least 2 cycles. This leaves one bubble cycle with no write-back on the cycle after the accepting edge, before the ack.
- **Stall timing:** `mem_stall` is high from edge N to edge M and low the cycle after M.
- **`wb_valid`:** never high for two consecutive cycles from the same instruction.

## Test plan
- **Reset:** assert `reset` mid-cycle with arbitrary inputs. All outputs are 0 immediately, state is IDLE, `mem_stall = 0`.
- **ALU pass-through:** `valid_in = 1`, `rdest_addr_in = 3'd5`, `rdest_data_in = 0x1234`, load/store = 0. After the next edge, `wb_valid = 1`, `wb_rdest_addr = 5`, `wb_rdest_data = 0x1234`; `dmem_req` stays 0.
- **Load, ack delayed 3 cycles:** `mem_addr_in = 0x00A0`, rd = 2, `dmem_rdata = 0xBEEF`.
  - `dmem_req = 1`, `dmem_we = 0`, `dmem_addr = 0x00A0`, `mem_stall = 1` for 3 cycles.
  - On ack: `wb_valid` pulses once with rd 2, data 0xBEEF; `mem_op_count = 1`.
- **Store then ALU back-to-back:** store with addr 0x0010, data 0x5555, and ack on the first BUSY cycle.
  - `dmem_we = 1`, `dmem_wdata = 0x5555`; no `wb_valid` for the store.
  - The held ALU op produces exactly one `wb_valid` in the cycle after its IDLE acceptance.
- **Reset during BUSY:** start a load, assert `reset` before ack. `dmem_req` drops immediately and `mem_op_count` stays 0; a later ack is ignored.
- **Counter wrap and priority:**
  - Preload 65535 completed ops (or force the count to 0xFFFF); the next op gives 0x0000.
  - An instruction with `load_in = store_in = 1` behaves as a store with no write-back.
